// File: rtl/sumador_ancho_ctrl_if.sv
// Requester-side handshake bundle for the nibble-serial wide adder sequencer.
// The master issues operands with start and collects result/cout on done.
interface sumador_ancho_ctrl_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin_in;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         cout;

  modport master (
    output start, op_a, op_b, cin_in,
    input  ready, done, result, cout
  );

  modport slave (
    input  start, op_a, op_b, cin_in,
    output ready, done, result, cout
  );
endinterface

// File: rtl/sumador_ancho_ctrl.sv
// Wide adder sequencer: feeds a shared registered 4-bit adder one nibble
// per pass, LSB first, chaining its carry-out back into the next carry-in.
module sumador_ancho_ctrl #(
  parameter int         N_NIBBLES = 4,
  parameter logic [1:0] MODO_SUMA = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  sumador_ancho_ctrl_if.slave req,
  output logic [3:0] sa_a,
  output logic [3:0] sa_b,
  output logic       sa_cin,
  output logic [1:0] sa_modo,
  output logic       sa_enb,
  input  logic [3:0] sa_q,
  input  logic       sa_rco
);
  localparam int W  = 4 * N_NIBBLES;
  localparam int IW = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_NIBBLES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] FIN     = 2'd3;

  logic [1:0]    state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          carry;
  logic [IW-1:0] idx;
  logic [W-1:0]  accum;
  logic [W-1:0]  accum_nx;
  logic [W-1:0]  result;
  logic          cout;
  logic [3:0]    nib_a;
  logic [3:0]    nib_b;

  always_comb begin
    nib_a    = 4'h0;
    nib_b    = 4'h0;
    accum_nx = accum;
    for (int i = 0; i < N_NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
        accum_nx[4*i +: 4] = sa_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      accum  <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req.start) begin
            a_q   <= req.op_a;
            b_q   <= req.op_b;
            carry <= req.cin_in;
            idx   <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          accum <= accum_nx;
          carry <= sa_rco;
          // result is taken from the next-state accum so the top nibble lands
          if (idx == LAST) begin
            result <= accum_nx;
            cout   <= sa_rco;
            state  <= FIN;
          end else begin
            idx   <= idx + 1'b1;
            state <= ISSUE;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign sa_enb  = (state == ISSUE);
  assign sa_a    = sa_enb ? nib_a : 4'h0;
  assign sa_b    = sa_enb ? nib_b : 4'h0;
  assign sa_cin  = sa_enb & carry;
  assign sa_modo = MODO_SUMA;

  assign req.ready  = (state == IDLE);
  assign req.done   = (state == FIN);
  assign req.result = result;
  assign req.cout   = cout;
endmodule

// File: tb/tb_sumador_ancho_ctrl.sv
// Bench for sumador_ancho_ctrl: table vectors, random ops against an
// arithmetic model, and hand-written reset / busy / single-nibble sequences.
module tb_sumador_ancho_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sumador_ancho_ctrl_if #(.W(16)) ra ();
  sumador_ancho_ctrl_if #(.W(4))  rb ();

  logic [3:0] a_sa_a, a_sa_b, a_sa_q;
  logic       a_sa_cin, a_sa_enb, a_sa_rco;
  logic [1:0] a_sa_modo;
  logic [3:0] b_sa_a, b_sa_b, b_sa_q;
  logic       b_sa_cin, b_sa_enb, b_sa_rco;
  logic [1:0] b_sa_modo;

  sumador_ancho_ctrl #(.N_NIBBLES(4), .MODO_SUMA(2'b00)) dut_a (
    .clk(clk), .rst(rst), .req(ra),
    .sa_a(a_sa_a), .sa_b(a_sa_b), .sa_cin(a_sa_cin),
    .sa_modo(a_sa_modo), .sa_enb(a_sa_enb),
    .sa_q(a_sa_q), .sa_rco(a_sa_rco)
  );

  sumador_ancho_ctrl #(.N_NIBBLES(1), .MODO_SUMA(2'b00)) dut_b (
    .clk(clk), .rst(rst), .req(rb),
    .sa_a(b_sa_a), .sa_b(b_sa_b), .sa_cin(b_sa_cin),
    .sa_modo(b_sa_modo), .sa_enb(b_sa_enb),
    .sa_q(b_sa_q), .sa_rco(b_sa_rco)
  );

  // registered 4-bit adder models
  always @(posedge clk)
    if (a_sa_enb)
      {a_sa_rco, a_sa_q} <= {1'b0, a_sa_a} + {1'b0, a_sa_b} + {4'b0, a_sa_cin};

  always @(posedge clk)
    if (b_sa_enb)
      {b_sa_rco, b_sa_q} <= {1'b0, b_sa_a} + {1'b0, b_sa_b} + {4'b0, b_sa_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] xres,
                        input logic xco, input bit inj, input string nm);
    int          done_k;
    int          n_done;
    int          n_enb;
    logic [11:0] enb_mask;
    logic [3:0]  cin_seen;
    logic [3:0]  cin_exp;
    logic [15:0] res_at;
    logic        co_at;
    logic [31:0] m;
    logic [31:0] s;
    bit          drop;
    done_k   = -1;
    n_done   = 0;
    n_enb    = 0;
    enb_mask = '0;
    cin_seen = '0;
    res_at   = '0;
    co_at    = 1'b0;
    drop     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m = (32'd1 << (4 * i)) - 32'd1;
      s = (32'(a) & m) + (32'(b) & m) + 32'(cin);
      s = s >> (4 * i);
      cin_exp[i] = s[0];
    end
    @(negedge clk);
    check({nm, "_ready_pre"}, 32'(ra.ready), 32'd1);
    ra.op_a   = a;
    ra.op_b   = b;
    ra.cin_in = cin;
    ra.start  = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) begin
        ra.start = 1'b0;
        if (inj) begin
          ra.op_a   = ~a;
          ra.op_b   = a ^ b;
          ra.cin_in = ~cin;
        end
      end
      enb_mask[k] = a_sa_enb;
      if (a_sa_enb) begin
        if (n_enb < 4) cin_seen[n_enb] = a_sa_cin;
        n_enb++;
      end
      if (drop) begin
        ra.start = 1'b0;
        drop     = 1'b0;
      end
      if (ra.done) begin
        n_done++;
        if (done_k < 0) begin
          done_k = k;
          res_at = ra.result;
          co_at  = ra.cout;
        end
        check({nm, "_ready_in_fin"}, 32'(ra.ready), 32'd0);
        if (inj) begin
          ra.start = 1'b1;
          ra.op_a  = 16'($urandom);
          drop     = 1'b1;
        end
      end
      if (inj && k == 3) begin
        ra.start = 1'b1;
        ra.op_a  = 16'($urandom);
        ra.op_b  = 16'($urandom);
      end
      if (inj && k == 4) ra.start = 1'b0;
    end
    check({nm, "_done_count"}, 32'(n_done), 32'd1);
    check({nm, "_done_cycle"}, 32'(done_k), 32'd8);
    check({nm, "_result"}, 32'(res_at), 32'(xres));
    check({nm, "_cout"}, 32'(co_at), 32'(xco));
    check({nm, "_enb_pattern"}, 32'(enb_mask), 32'h055);
    check({nm, "_cin_chain"}, 32'(cin_seen), 32'(cin_exp));
    check({nm, "_result_hold"}, 32'(ra.result), 32'(xres));
    check({nm, "_ready_post"}, 32'(ra.ready), 32'd1);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] res;
    logic        co;
    bit          inj;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [15:0] ra_v;
    logic [15:0] rb_v;
    logic        rc_v;
    logic [16:0] sum;
    int          n_done;
    int          done_k;
    checks   = 0;
    failures = 0;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    tbl[3] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[5] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b1};
    tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    rst       = 1'b1;
    ra.start  = 1'b0;
    ra.op_a   = '0;
    ra.op_b   = '0;
    ra.cin_in = 1'b0;
    rb.start  = 1'b0;
    rb.op_a   = '0;
    rb.op_b   = '0;
    rb.cin_in = 1'b0;

    #12;
    check("rst_ready", 32'(ra.ready), 32'd1);
    check("rst_done", 32'(ra.done), 32'd0);
    check("rst_result", 32'(ra.result), 32'd0);
    check("rst_cout", 32'(ra.cout), 32'd0);
    check("rst_enb", 32'(a_sa_enb), 32'd0);
    check("rst_sa_a", 32'(a_sa_a), 32'd0);
    check("rst_modo", 32'(a_sa_modo), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].res, tbl[i].co,
             tbl[i].inj, $sformatf("vec%0d", i));

    // async reset while ISSUE is being driven
    @(negedge clk);
    ra.op_a   = 16'h1234;
    ra.op_b   = 16'h4321;
    ra.cin_in = 1'b0;
    ra.start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ra.start = 1'b0;
    check("mid_issue_enb", 32'(a_sa_enb), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_enb", 32'(a_sa_enb), 32'd0);
    check("async_ready", 32'(ra.ready), 32'd1);
    check("async_result", 32'(ra.result), 32'd0);
    check("async_cout", 32'(ra.cout), 32'd0);
    check("async_modo", 32'(a_sa_modo), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // abort at cycle 4 of an op
    @(negedge clk);
    ra.op_a   = 16'hFFFF;
    ra.op_b   = 16'h0001;
    ra.start  = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ra.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ra.done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_result", 32'(ra.result), 32'd0);
    run_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, "after_abort");

    for (int i = 0; i < 20; i++) begin
      ra_v = 16'($urandom);
      rb_v = 16'($urandom);
      rc_v = 1'($urandom_range(0, 1));
      sum  = {1'b0, ra_v} + {1'b0, rb_v} + 17'(rc_v);
      run_op(ra_v, rb_v, rc_v, sum[15:0], sum[16], (i % 5) == 0,
             $sformatf("rnd%0d", i));
    end

    // single-nibble instance
    @(negedge clk);
    rb.op_a   = 4'h9;
    rb.op_b   = 4'h8;
    rb.cin_in = 1'b1;
    rb.start  = 1'b1;
    @(posedge clk);
    n_done = 0;
    done_k = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rb.start = 1'b0;
      if (rb.done) begin
        n_done++;
        if (done_k < 0) begin
          done_k = k;
          check("n1_result", 32'(rb.result), 32'h2);
          check("n1_cout", 32'(rb.cout), 32'd1);
        end
      end
    end
    check("n1_done_count", 32'(n_done), 32'd1);
    check("n1_done_cycle", 32'(done_k), 32'd2);
    check("n1_ready_post", 32'(rb.ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
